// File: rtl/mux_tree_pkg.sv
// Shared mode encodings and the round-robin channel search used by mux_tree_pipe.
// Supports select widths up to MAX_SEL.
package mux_tree_pkg;

    localparam logic MODE_EXT  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    localparam int unsigned MAX_SEL = 6;
    localparam int unsigned MAX_N   = 1 << MAX_SEL;

    // First enabled channel at or above ptr, wrapping at n-1 -> 0. Returns 0 for an empty mask.
    function automatic int unsigned next_enabled(
        input logic [MAX_SEL-1:0] ptr,
        input logic [MAX_N-1:0]   mask,
        input int unsigned        n
    );
        int unsigned idx;
        int unsigned ch;
        logic        found;
        ch    = 0;
        found = 1'b0;
        for (int unsigned d = 0; d < MAX_N; d++) begin
            idx = (32'(ptr) + d) % n;
            if (!found && (d < n) && mask[idx[MAX_SEL-1:0]]) begin
                ch    = idx;
                found = 1'b1;
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_stage.sv
// One registered 2:1 reduction level of the mux tree; 1-cycle latency.
// Holds all state when i_adv is low.
module mux_stage #(
    parameter int WORDS = 8,
    parameter int W     = 8,
    parameter int TAGW  = 3,
    parameter int LVL   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_adv,
    input  logic                     i_vld,
    input  logic [WORDS*W-1:0]       i_dat,
    input  logic [TAGW-1:0]          i_tag,
    output logic                     o_vld,
    output logic [(WORDS/2)*W-1:0]   o_dat,
    output logic [TAGW-1:0]          o_tag
);

    localparam int OWORDS = WORDS / 2;

    logic                   r_vld;
    logic [OWORDS*W-1:0]    r_dat;
    logic [TAGW-1:0]        r_tag;
    logic [OWORDS*W-1:0]    w_red;

    // The tag is the original select, so the unconsumed select bits are the tag bits above LVL.
    always_comb begin
        w_red = '0;
        for (int j = 0; j < OWORDS; j++) begin
            w_red[j*W +: W] = i_tag[LVL] ? i_dat[(2*j+1)*W +: W] : i_dat[(2*j)*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
            r_tag <= '0;
        end else if (i_adv) begin
            r_vld <= i_vld;
            r_dat <= w_red;
            r_tag <= i_tag;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;
    assign o_tag = r_tag;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree with channel tag and optional round-robin scan; SEL-cycle latency.
// Whole pipe holds while o_valid && !o_ready; i_ready drops with it or on an empty scan mask.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int W   = 8,
    parameter int SEL = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [(1<<SEL)*W-1:0] i,
    input  logic [SEL-1:0]       s,
    input  logic                 mode,
    input  logic [(1<<SEL)-1:0]  en_mask,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [W-1:0]         o,
    output logic [SEL-1:0]       o_ch,
    output logic                 o_valid,
    input  logic                 o_ready
);

    localparam int N = 1 << SEL;

    logic            w_adv;
    logic            w_blocked;
    logic            w_acc;
    logic [SEL-1:0]  w_scan_ch;
    logic [SEL-1:0]  w_ch;
    logic [SEL-1:0]  r_ptr;

    assign w_adv     = !o_valid || o_ready;
    assign w_blocked = (mode == MODE_SCAN) && (en_mask == '0);
    assign i_ready   = w_adv && !w_blocked;
    assign w_acc     = i_valid && i_ready;

    assign w_scan_ch = SEL'(next_enabled(MAX_SEL'(r_ptr), MAX_N'(en_mask), N));
    assign w_ch      = (mode == MODE_EXT) ? s : w_scan_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_acc && (mode == MODE_SCAN)) begin
            r_ptr <= w_scan_ch + SEL'(1);
        end
    end

    // All tree levels packed back to back: level j starts at word 2N - 2*(N>>j) and holds N>>j words.
    logic [(2*N-1)*W-1:0] w_lvl;
    logic                 w_vld [0:SEL];
    logic [SEL-1:0]       w_tag [0:SEL];

    assign w_lvl[N*W-1:0] = w_acc ? i : '0;
    assign w_vld[0]       = w_acc;
    assign w_tag[0]       = w_acc ? w_ch : '0;

    genvar k;
    generate
        for (k = 0; k < SEL; k++) begin : g_stage
            localparam int WIN  = N >> k;
            localparam int OFFI = 2*N - 2*(N >> k);
            localparam int OFFO = 2*N - 2*(N >> (k+1));

            mux_stage #(
                .WORDS (WIN),
                .W     (W),
                .TAGW  (SEL),
                .LVL   (k)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .i_adv (w_adv),
                .i_vld (w_vld[k]),
                .i_dat (w_lvl[OFFI*W +: WIN*W]),
                .i_tag (w_tag[k]),
                .o_vld (w_vld[k+1]),
                .o_dat (w_lvl[OFFO*W +: (WIN/2)*W]),
                .o_tag (w_tag[k+1])
            );
        end
    endgenerate

    assign o       = w_lvl[(2*N-2)*W +: W];
    assign o_ch    = w_tag[SEL];
    assign o_valid = w_vld[SEL];

endmodule
